// File: rtl/cluster_pwr_seq_if.sv
// cluster_pwr_seq_if: control requests in, cluster power/clock/reset/fetch controls and status out
interface cluster_pwr_seq_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  pwr_req;
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] boot_addr;
  logic                  cluster_busy;
  logic                  cluster_pow;
  logic                  cluster_clk_en;
  logic                  cluster_rstn;
  logic                  cluster_fetch_en;
  logic [ADDR_WIDTH-1:0] cluster_boot_addr;
  logic                  pwr_ack;
  logic [3:0]            pwr_state;
  logic                  irq;
  logic                  timeout;
  modport master (
    output pwr_req, fetch_req, boot_addr, cluster_busy,
    input  cluster_pow, cluster_clk_en, cluster_rstn, cluster_fetch_en,
           cluster_boot_addr, pwr_ack, pwr_state, irq, timeout
  );
  modport slave (
    input  pwr_req, fetch_req, boot_addr, cluster_busy,
    output cluster_pow, cluster_clk_en, cluster_rstn, cluster_fetch_en,
           cluster_boot_addr, pwr_ack, pwr_state, irq, timeout
  );
endinterface

// File: rtl/cluster_pwr_seq.sv
// cluster_pwr_seq: sequences cluster supply, clock gate, reset release, fetch enable and boot address
module cluster_pwr_seq #(
  parameter int POW_SETTLE   = 16,
  parameter int CLK_SETTLE   = 8,
  parameter int RST_HOLD     = 4,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int ADDR_WIDTH   = 64
) (
  input logic              clk,
  input logic              rst,
  cluster_pwr_seq_if.slave bus
);
  localparam int PS = POW_SETTLE < 1 ? 1 : POW_SETTLE;
  localparam int CS = CLK_SETTLE < 1 ? 1 : CLK_SETTLE;
  localparam int RH = RST_HOLD < 1 ? 1 : RST_HOLD;
  localparam int MX = PS > CS ? (PS > RH ? PS : RH) : (CS > RH ? CS : RH);
  localparam int CW = $clog2(MX + 1);
  localparam int DW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [3:0] {
    OFF, PWR_UP, CLK_EN, RST_REL, ON, DRAIN, RST_ASSERT, CLK_DIS, PWR_DN
  } state_t;

  state_t                st, nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [DW-1:0]         dcnt;
  logic                  idle, to;
  logic [ADDR_WIDTH-1:0] boot_q;

  assign bus.pwr_state         = st;
  assign bus.cluster_boot_addr = boot_q;

  // next state: timed states leave at count 0, up path aborts on req drop, drain exits on idle or timeout
  always_comb begin
    nx     = st;
    cnt_nx = cnt == '0 ? cnt : cnt - 1'b1;
    to     = 1'b0;
    case (st)
      OFF:        if (bus.pwr_req) begin nx = PWR_UP; cnt_nx = CW'(PS - 1); end
      PWR_UP:     if (!bus.pwr_req) begin nx = PWR_DN; cnt_nx = CW'(PS - 1); end
                  else if (cnt == '0) begin nx = CLK_EN; cnt_nx = CW'(CS - 1); end
      CLK_EN:     if (!bus.pwr_req) begin nx = CLK_DIS; cnt_nx = CW'(CS - 1); end
                  else if (cnt == '0) begin nx = RST_REL; cnt_nx = CW'(RH - 1); end
      RST_REL:    if (!bus.pwr_req) begin nx = RST_ASSERT; cnt_nx = CW'(RH - 1); end
                  else if (cnt == '0) nx = ON;
      ON:         if (!bus.pwr_req) nx = DRAIN;
      DRAIN:      if (!bus.cluster_busy && idle) begin nx = RST_ASSERT; cnt_nx = CW'(RH - 1); end
                  else if (dcnt == DW'(BUSY_TIMEOUT - 1)) begin nx = RST_ASSERT; cnt_nx = CW'(RH - 1); to = 1'b1; end
      RST_ASSERT: if (cnt == '0) begin nx = CLK_DIS; cnt_nx = CW'(CS - 1); end
      CLK_DIS:    if (cnt == '0) begin nx = PWR_DN; cnt_nx = CW'(PS - 1); end
      PWR_DN:     if (cnt == '0) nx = OFF;
      default:    nx = OFF;
    endcase
  end

  // state, counters and registered Moore outputs decoded from the next state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st                   <= OFF;
      cnt                  <= '0;
      dcnt                 <= '0;
      idle                 <= 1'b0;
      boot_q               <= '0;
      bus.cluster_pow      <= 1'b0;
      bus.cluster_clk_en   <= 1'b0;
      bus.cluster_rstn     <= 1'b0;
      bus.cluster_fetch_en <= 1'b0;
      bus.pwr_ack          <= 1'b0;
      bus.irq              <= 1'b0;
      bus.timeout          <= 1'b0;
    end else begin
      st                   <= nx;
      cnt                  <= cnt_nx;
      dcnt                 <= (st == DRAIN && nx == DRAIN) ? dcnt + 1'b1 : '0;
      idle                 <= st == DRAIN && !bus.cluster_busy;
      boot_q               <= (st == RST_REL && nx == ON) ? bus.boot_addr : boot_q;
      bus.cluster_pow      <= nx != OFF && nx != PWR_DN;
      bus.cluster_clk_en   <= nx inside {CLK_EN, RST_REL, ON, DRAIN, RST_ASSERT, CLK_DIS};
      bus.cluster_rstn     <= nx == ON || nx == DRAIN;
      bus.cluster_fetch_en <= st == ON && bus.fetch_req;
      bus.pwr_ack          <= nx == ON;
      bus.irq              <= (nx == ON && st != ON) || (nx == OFF && st == PWR_DN);
      bus.timeout          <= to;
    end
endmodule
